// File: rtl/ex_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_ctrl
// Purpose  : Iterative RV32M multiply/divide unit for the EX stage. It does
//            32-step shift-add multiply and restoring divide on operand
//            magnitudes, then applies a sign fix-up step. It stalls the
//            pipeline while busy and pulses done with the result.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] prod_q, prod_d;     // multiply: {hi,lo} product; divide: {remainder, quotient}
    logic [31:0] mcand_q, mcand_d;   // multiplicand or divisor magnitude
    logic [2:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic        neg_q, neg_d;       // operand signs differ
    logic        rsign_q, rsign_d;   // dividend was negative
    logic [31:0] result_q, result_d;
    logic [4:0]  rdout_q, rdout_d;

    // Operand decode for the op being presented at the EX input
    logic        w_sgn1, w_sgn2, w_neg1, w_neg2;
    logic [31:0] w_mag1, w_mag2;
    logic        w_div0, w_ovf;
    logic [31:0] w_special;

    assign w_sgn1    = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    assign w_sgn2    = op[2] ? ~op[0] : ~op[1];
    assign w_neg1    = w_sgn1 & src1[31];
    assign w_neg2    = w_sgn2 & src2[31];
    assign w_mag1    = w_neg1 ? (32'd0 - src1) : src1;
    assign w_mag2    = w_neg2 ? (32'd0 - src2) : src2;
    assign w_div0    = op[2] & (src2 == 32'd0);
    assign w_ovf     = op[2] & ~op[0] & (src1 == 32'h8000_0000) & (src2 == 32'hFFFF_FFFF);
    assign w_special = op[1] ? (w_div0 ? src1 : 32'd0)
                             : (w_div0 ? 32'hFFFF_FFFF : 32'h8000_0000);

    // Iteration datapath: one shift-add or one trial subtraction per cycle
    logic [32:0] w_sum, w_trial;
    assign w_sum   = {1'b0, prod_q[63:32]} + {1'b0, (prod_q[0] ? mcand_q : 32'd0)};
    assign w_trial = prod_q[63:31] - {1'b0, mcand_q};

    // Sign fix-up and result selection from the latched op
    logic [63:0] w_prod_s;
    logic [31:0] w_quo_s, w_rem_s, w_fix;
    assign w_prod_s = neg_q   ? (64'd0 - prod_q)         : prod_q;
    assign w_quo_s  = neg_q   ? (32'd0 - prod_q[31:0])   : prod_q[31:0];
    assign w_rem_s  = rsign_q ? (32'd0 - prod_q[63:32])  : prod_q[63:32];

    // Pick the architectural result for the latched funct3
    always_comb begin
        w_fix = w_prod_s[31:0];
        case (op_q)
            3'b000:                 w_fix = w_prod_s[31:0];
            3'b001, 3'b010, 3'b011: w_fix = w_prod_s[63:32];
            3'b100, 3'b101:         w_fix = w_quo_s;
            default:                w_fix = w_rem_s;
        endcase
    end

    // Next-state, datapath update and stall/done generation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        op_d     = op_q;
        rd_d     = rd_q;
        neg_d    = neg_q;
        rsign_d  = rsign_q;
        result_d = result_q;
        rdout_d  = rdout_q;
        stall    = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    stall   = 1'b1;
                    op_d    = op;
                    rd_d    = rd_in;
                    neg_d   = w_neg1 ^ w_neg2;
                    rsign_d = w_neg1;
                    cnt_d   = 5'd0;
                    mcand_d = w_mag2;
                    prod_d  = {32'd0, w_mag1};
                    if (w_div0 || w_ovf) begin
                        // Corner cases have a fixed answer; skip the iterations
                        result_d = w_special;
                        rdout_d  = rd_in;
                        state_d  = S_DONE;
                    end else begin
                        state_d = op[2] ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL: begin
                stall  = 1'b1;
                prod_d = {w_sum, prod_q[31:1]};
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_DIV: begin
                stall = 1'b1;
                if (!w_trial[32]) prod_d = {w_trial[31:0], prod_q[30:0], 1'b1};
                else              prod_d = {prod_q[62:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_FIX: begin
                stall    = 1'b1;
                result_d = w_fix;
                rdout_d  = rd_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A killed op must not disturb the visible result registers
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
            rdout_d  = rdout_q;
        end
        if (!resetn) stall = 1'b0;
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            prod_q   <= 64'd0;
            mcand_q  <= 32'd0;
            op_q     <= 3'd0;
            rd_q     <= 5'd0;
            neg_q    <= 1'b0;
            rsign_q  <= 1'b0;
            result_q <= 32'd0;
            rdout_q  <= 5'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            neg_q    <= neg_d;
            rsign_q  <= rsign_d;
            result_q <= result_d;
            rdout_q  <= rdout_d;
        end
    end

    assign result = result_q;
    assign rd_out = rdout_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_ctrl
// Purpose  : Self-checking bench for ex_muldiv_ctrl: directed vector table,
//            randomized ops against an arithmetic reference model, and
//            flush / mid-op reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        resetn, start, flush;
    logic [2:0]  op;
    logic [31:0] src1, src2;
    logic [4:0]  rd_in;
    logic        stall, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int tests = 0;
    int fails = 0;

    ex_muldiv_ctrl #(.XLEN(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .rd_in  (rd_in),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // RV32M semantics computed with wide integer arithmetic
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 34;
    endfunction

    // Watch cycles after the start cycle until done; check latency, stall, result
    task automatic wait_done(input int lat, input logic [31:0] er, input logic [4:0] erd, input string name);
        int got = 0;
        int bad_stall = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done) begin
                got = k;
                break;
            end
            if (stall !== 1'b1) bad_stall++;
        end
        check({name, "_latency"}, got, lat);
        check({name, "_busy_stall"}, bad_stall, 0);
        if (got != 0) begin
            check({name, "_result"}, result, er);
            check({name, "_rd_out"}, rd_out, erd);
            check({name, "_done_stall"}, stall, 0);
        end
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] er, input int lat, input string name);
        @(negedge clk);
        start = 1'b1; op = f3; src1 = a; src2 = b; rd_in = rd;
        #1;
        check({name, "_start_stall"}, stall, 1);
        check({name, "_idle_done"}, done, 0);
        wait_done(lat, er, rd, name);
    endtask

    initial begin
        int bad;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        logic [4:0]  rrd;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         34};
        vecs[13] = '{3'd0, 32'd3,          32'd4,         32'd12,        34};

        resetn = 1'b0; start = 1'b0; flush = 1'b0;
        op = 3'd0; src1 = '0; src2 = '0; rd_in = '0;

        // Reset state; stall must stay low even with start requested
        repeat (2) @(negedge clk);
        start = 1'b1; src1 = 32'd5; src2 = 32'd3; rd_in = 5'd4;
        #1;
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_rd_out", rd_out, 0);
        @(negedge clk);
        start = 1'b0; resetn = 1'b1;

        // Directed vectors, issued back to back
        for (int i = 0; i < 14; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

        // Randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            rrd = 5'($urandom);
            case ($urandom_range(0, 15))
                0, 1: rb = 32'd0;
                2:    begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3:    rb = 32'($urandom_range(1, 15));
                4:    ra = 32'($urandom_range(0, 255));
                default: ;
            endcase
            run_op(rf3, ra, rb, rrd, model(rf3, ra, rb), model_lat(rf3, ra, rb), $sformatf("rnd%0d", i));
        end

        // Flush a DIV at T+10, start MUL 3x4 at T+11
        @(negedge clk);
        start = 1'b1; op = 3'd5; src1 = 32'd100; src2 = 32'd7; rd_in = 5'd21;
        bad = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 10) flush = 1'b1;
            #1;
            if (done) bad++;
        end
        @(negedge clk);
        flush = 1'b0;
        start = 1'b1; op = 3'd0; src1 = 32'd3; src2 = 32'd4; rd_in = 5'd9;
        #1;
        check("flush_no_done", bad, 0);
        check("flush_restart_stall", stall, 1);
        check("flush_restart_done", done, 0);
        wait_done(34, 32'd12, 5'd9, "flush_mul");

        // Reset at T+20 of a MUL
        @(negedge clk);
        start = 1'b1; op = 3'd0; src1 = 32'd7; src2 = 32'hFFFF_FFFD; rd_in = 5'd17;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 20) resetn = 1'b0;
        end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("midrst_result", result, 0);
        check("midrst_rd_out", rd_out, 0);
        check("midrst_done", done, 0);
        check("midrst_stall", stall, 0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (done) bad++;
        end
        check("midrst_no_done", bad, 0);
        run_op(3'd5, 32'd100, 32'd7, 5'd3, 32'd14, 34, "post_rst");
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd30, 32'hFFFF_FFEB, 34, "post_rst_mul");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

endmodule
`default_nettype wire
